// File: rtl/mv_seq_ctrl.sv
// Binary-vector x 6x6 byte matrix sequencer: each result column takes six accumulate cycles.
// A finished column is held on res_valid until res_ready; abort or rst drops the product.
module mv_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [5:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  input  logic        start,
  input  logic [5:0]  vec,
  input  logic        abort,
  output logic        busy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [10:0] res_data,
  output logic [2:0]  res_idx,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, ACC, OUT, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  m [36];
  logic [5:0]  vec_q;
  logic [2:0]  col, row;
  logic [10:0] acc, sum;
  logic [5:0]  rd_idx;

  assign rd_idx = 6'(row) * 6'd6 + 6'(col);
  assign sum    = acc + (vec_q[row] ? {3'b000, m[rd_idx]} : 11'd0);

  assign busy      = (state != IDLE);
  assign res_valid = (state == OUT);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = ACC;
      ACC: begin
        if (abort)            state_nxt = IDLE;
        else if (row == 3'd5) state_nxt = OUT;
      end
      // abort wins over a simultaneous acceptance
      OUT: begin
        if (abort)          state_nxt = IDLE;
        else if (res_ready) state_nxt = (col == 3'd5) ? DONE : ACC;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Weights are only writable while idle, so a running product never sees a partial update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 36; i++) m[i] <= 8'((i / 6) * 16 + (i % 6) + 1);
    end else if (state == IDLE && cfg_we && cfg_addr < 6'd36) begin
      m[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q    <= '0;
      col      <= '0;
      row      <= '0;
      acc      <= '0;
      res_data <= '0;
      res_idx  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          vec_q <= vec;
          col   <= '0;
          row   <= '0;
          acc   <= '0;
        end
        ACC: if (!abort) begin
          acc <= sum;
          row <= row + 3'd1;
          if (row == 3'd5) begin
            res_data <= sum;
            res_idx  <= col;
          end
        end
        OUT: if (!abort && res_ready) begin
          if (col != 3'd5) col <= col + 3'd1;
          row <= '0;
          acc <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mv_seq_ctrl.md
MV_SEQ_CTRL -- requirements
Module: mv_seq_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 cfg_we  input  1  matrix byte write strobe.
REQ-005 cfg_addr  input  6  matrix byte address, row*6+col, valid range 0..35.
REQ-006 cfg_data  input  8  matrix byte write data.
REQ-007 start  input  1  begin one matrix-vector product.
REQ-008 vec  input  6  binary input vector, bit j selects row j; sampled with start.
REQ-009 abort  input  1  synchronous cancel of the current product.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 res_valid  output  1  result element available.
REQ-012 res_ready  input  1  consumer accepts result element.
REQ-013 res_data  output  11  result element value.
REQ-014 res_idx  output  3  result element index (column), 0..5.
REQ-015 done  output  1  one-cycle pulse after the last element is accepted.

Function
REQ-016 The block SHALL hold a 6x6 array M of 8-bit unsigned weights and one shared 11-bit accumulator.
REQ-017 result[c] SHALL equal the sum over j=0..5 of vec[j]*M[j][c], unsigned, 11 bits (maximum 6*255=1530), with no overflow possible.
REQ-018 FSM states SHALL be IDLE, ACC, OUT and DONE.
REQ-019 IDLE: cfg_we with cfg_addr<=35 SHALL write cfg_data to M[addr/6][addr%6] at the edge; cfg_addr>=36 SHALL be ignored.
REQ-020 cfg_we outside IDLE SHALL be ignored; M is unchanged.
REQ-021 IDLE with start=1 SHALL latch vec, set column c=0, row j=0, accumulator=0 and enter ACC; if cfg_we and start coincide, the write SHALL complete and the product SHALL use the updated M.
REQ-022 ACC: each edge SHALL add (vec[j] ? M[j][c] : 0) to the accumulator and increment j; the edge that adds j=5 SHALL enter OUT with res_data = final sum and res_idx = c.
REQ-023 Latency: res_valid SHALL rise after the 6th rising edge following the edge that samples start (and following each accepted element for the next column).
REQ-024 OUT: res_valid=1; res_data and res_idx SHALL stay stable until res_valid&res_ready at an edge.
REQ-025 On acceptance with c<5: c increments, j=0, accumulator=0, state returns to ACC, and res_valid is low the next cycle.
REQ-026 On acceptance with c=5: state SHALL enter DONE; DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 start while busy SHALL be ignored; vec changes after latching SHALL have no effect.
REQ-028 abort=1 in ACC or OUT SHALL return to IDLE at the next edge, drop res_valid, and never assert done; abort has priority over res_ready acceptance; abort in IDLE or DONE SHALL have no effect.
REQ-029 res_ready while res_valid=0 SHALL be ignored.

Reset
REQ-030 rst SHALL asynchronously force IDLE, busy=0, res_valid=0, done=0, res_data=0, res_idx=0, accumulator=0, c=0 and j=0.
REQ-031 rst SHALL load M[r][c] = r*16+c+1 (default pattern, e.g. M[0][0]=1, M[5][5]=86).
REQ-032 Reset asserted mid-product SHALL discard the product with no done pulse; after release the block SHALL accept a new start.

Verification
REQ-033 Reset, vec=6'b000001, start, res_ready=1 -> results c0..c5 = 1,2,3,4,5,6; done pulses once; each element arrives 6 cycles after the previous acceptance.
REQ-034 Reset, vec=6'b111111 -> results 246,252,258,264,270,276.
REQ-035 Write 255 to all 36 addresses, vec=6'b111111 -> every result = 1530; a write to address 40 leaves M unchanged.
REQ-036 res_ready held low 10 cycles in OUT -> res_valid, res_data and res_idx held constant; single transfer on release.
REQ-037 abort at ACC j=3 of column 2 -> IDLE next edge, no done; a following start with vec=0 yields six results of 0.
REQ-038 cfg_we and start during busy, then rst in OUT -> M unchanged by the write, second start ignored; after reset all outputs are 0 and M equals the default pattern.
